// File: rtl/rfm_sched_pkg.sv
// Shared FSM encoding and default parameter constants for the RFM scheduler.
package rfm_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_COOL  = 2'd3
    } state_t;

    localparam int DEF_NUM_BANK  = 4;
    localparam int DEF_BANK_BITS = 2;
    localparam int DEF_RFM_TH    = 8;
    localparam int DEF_RAA_MAX   = 32;
    localparam int DEF_CNT_BITS  = 6;
    localparam int DEF_T_WAIT    = 8;
    localparam int DEF_T_RFM     = 16;

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arb
    import rfm_sched_pkg::*;
#(
    parameter int NUM_BANK  = DEF_NUM_BANK,
    parameter int BANK_BITS = DEF_BANK_BITS
) (
    input  logic [NUM_BANK-1:0]  req,
    input  logic [BANK_BITS-1:0] ptr,
    output logic [NUM_BANK-1:0]  gnt,
    output logic [BANK_BITS-1:0] gnt_idx,
    output logic                 gnt_vld
);

    logic [BANK_BITS-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_BANK; i++) begin
            idx = BANK_BITS'((int'(ptr) + i) % NUM_BANK);
            if (!gnt_vld && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                gnt_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rfm_sched.sv
// Per-bank rolling activation counters and the RFM issue/wait/cooldown scheduler.
module rfm_sched
    import rfm_sched_pkg::*;
#(
    parameter int NUM_BANK  = DEF_NUM_BANK,
    parameter int BANK_BITS = DEF_BANK_BITS,
    parameter int RFM_TH    = DEF_RFM_TH,
    parameter int RAA_MAX   = DEF_RAA_MAX,
    parameter int CNT_BITS  = DEF_CNT_BITS,
    parameter int T_WAIT    = DEF_T_WAIT,
    parameter int T_RFM     = DEF_T_RFM
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 act_cmd,
    input  logic [BANK_BITS-1:0] act_bank,
    input  logic [NUM_BANK-1:0]  nrr_cmd,
    output logic [NUM_BANK-1:0]  rfm_cmd,
    output logic                 act_stall,
    output logic                 busy,
    output logic [BANK_BITS-1:0] cur_bank,
    output logic                 alert,
    output logic                 timeout_err
);

    localparam int TMR_MAX  = (T_WAIT > T_RFM) ? T_WAIT : T_RFM;
    localparam int TMR_BITS = $clog2(TMR_MAX + 1);

    state_t               state, state_nxt;
    logic [CNT_BITS-1:0]  cnt [NUM_BANK];
    logic [NUM_BANK-1:0]  req, gnt, cur_oh;
    logic [BANK_BITS-1:0] gnt_idx, rr_ptr;
    logic                 gnt_vld;
    logic [TMR_BITS-1:0]  timer;

    always_comb begin
        req   = '0;
        alert = 1'b0;
        for (int b = 0; b < NUM_BANK; b++) begin
            req[b] = (cnt[b] >= CNT_BITS'(RFM_TH));
            if (cnt[b] == CNT_BITS'(RAA_MAX))
                alert = 1'b1;
        end
    end

    rr_arb #(
        .NUM_BANK  (NUM_BANK),
        .BANK_BITS (BANK_BITS)
    ) u_arb (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        state_nxt = state;
        rfm_cmd   = '0;
        act_stall = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (gnt_vld)
                    state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                rfm_cmd   = cur_oh;
                act_stall = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (nrr_cmd[cur_bank] || timer == TMR_BITS'(T_WAIT - 1))
                    state_nxt = ST_COOL;
            end
            ST_COOL: begin
                if (timer == TMR_BITS'(T_RFM - 1))
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            cur_bank    <= '0;
            cur_oh      <= '0;
            timer       <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && gnt_vld) begin
                cur_bank <= gnt_idx;
                cur_oh   <= gnt;
                rr_ptr   <= (gnt_idx == BANK_BITS'(NUM_BANK - 1)) ? '0 : gnt_idx + 1'b1;
            end
            // Timer restarts on every state change, so WAIT and COOL each count from zero.
            if (state_nxt != state)
                timer <= '0;
            else if (state == ST_WAIT || state == ST_COOL)
                timer <= timer + 1'b1;
            if (state == ST_WAIT && !nrr_cmd[cur_bank] && timer == TMR_BITS'(T_WAIT - 1))
                timeout_err <= 1'b1;
        end
    end

    // The ISSUE decrement has priority; any ACT that cycle is already stalled.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANK; b++) begin
            if (!rstn)
                cnt[b] <= '0;
            else if (state == ST_ISSUE && cur_bank == BANK_BITS'(b))
                cnt[b] <= (cnt[b] >= CNT_BITS'(RFM_TH)) ? cnt[b] - CNT_BITS'(RFM_TH) : '0;
            else if (act_cmd && !act_stall && act_bank == BANK_BITS'(b) &&
                     cnt[b] != CNT_BITS'(RAA_MAX))
                cnt[b] <= cnt[b] + 1'b1;
        end
    end

endmodule
